// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB dest flags, forwarding selects, ID bypass, load-use stall, hold freeze.
// Optional stall performance counter is compiled in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_useRs,
  input  logic          id_useRt,
  input  logic [AW-1:0] id_wrAddr,
  input  logic          id_regWrite,
  input  logic          id_memtoReg,
  output logic          pcWrite,
  output logic          ifidWrite,
  output logic          idexBubble,
  output logic          pipeWrite,
  output logic [1:0]    fwdA,
  output logic [1:0]    fwdB,
  output logic          idBypA,
  output logic          idBypB,
  output logic [31:0]   stallCount
);

  typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_wr_q, ex_wr_d;
  logic          ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;
  logic          ex_rw_q, ex_rw_d, ex_mtr_q, ex_mtr_d;
  logic [AW-1:0] mem_wr_q, mem_wr_d, wb_wr_q, wb_wr_d;
  logic          mem_rw_q, mem_rw_d, mem_mtr_q, mem_mtr_d, wb_rw_q, wb_rw_d;
  logic          freeze, lu, ex_load;

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [AW-1:0] r,
                                         input logic [AW-1:0] m_wr, input logic m_rw, input logic m_mtr,
                                         input logic [AW-1:0] w_wr, input logic w_rw);
    fwd_sel = 2'b00;
    if (use_r && m_rw && m_wr != '0 && m_wr == r && !m_mtr) fwd_sel = 2'b01;
    else if (use_r && w_rw && w_wr != '0 && w_wr == r)       fwd_sel = 2'b10;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (hold)  state_d = S_HOLD;
      S_HOLD:  if (!hold) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    // hold acts in the cycle it is raised, so the freeze follows the next state
    freeze  = (state_d == S_HOLD);
    ex_load = ex_rw_q && ex_mtr_q && (ex_wr_q != '0);
    lu      = id_valid && ex_load &&
              ((id_useRs && ex_wr_q == id_rs) || (id_useRt && ex_wr_q == id_rt));

    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    pipeWrite  = 1'b0;
    idexBubble = 1'b1;
    fwdA       = 2'b00;
    fwdB       = 2'b00;
    idBypA     = 1'b0;
    idBypB     = 1'b0;
    if (rst) begin
      idexBubble = 1'b0;
      if (!freeze) begin
        pipeWrite  = 1'b1;
        pcWrite    = !lu;
        ifidWrite  = !lu;
        idexBubble = lu;
      end
      fwdA   = fwd_sel(ex_use_rs_q, ex_rs_q, mem_wr_q, mem_rw_q, mem_mtr_q, wb_wr_q, wb_rw_q);
      fwdB   = fwd_sel(ex_use_rt_q, ex_rt_q, mem_wr_q, mem_rw_q, mem_mtr_q, wb_wr_q, wb_rw_q);
      idBypA = id_useRs && wb_rw_q && wb_wr_q != '0 && wb_wr_q == id_rs;
      idBypB = id_useRt && wb_rw_q && wb_wr_q != '0 && wb_wr_q == id_rt;
    end

    ex_rs_d = ex_rs_q;  ex_rt_d = ex_rt_q;  ex_wr_d = ex_wr_q;
    ex_use_rs_d = ex_use_rs_q;  ex_use_rt_d = ex_use_rt_q;
    ex_rw_d = ex_rw_q;  ex_mtr_d = ex_mtr_q;
    mem_wr_d = mem_wr_q;  mem_rw_d = mem_rw_q;  mem_mtr_d = mem_mtr_q;
    wb_wr_d = wb_wr_q;  wb_rw_d = wb_rw_q;
    if (pipeWrite) begin
      wb_wr_d   = mem_wr_q;
      wb_rw_d   = mem_rw_q;
      mem_wr_d  = ex_wr_q;
      mem_rw_d  = ex_rw_q;
      mem_mtr_d = ex_mtr_q;
      if (idexBubble || !id_valid) begin
        ex_rs_d = '0;  ex_rt_d = '0;  ex_wr_d = '0;
        ex_use_rs_d = 1'b0;  ex_use_rt_d = 1'b0;
        ex_rw_d = 1'b0;  ex_mtr_d = 1'b0;
      end else begin
        ex_rs_d = id_rs;  ex_rt_d = id_rt;  ex_wr_d = id_wrAddr;
        ex_use_rs_d = id_useRs;  ex_use_rt_d = id_useRt;
        ex_rw_d = id_regWrite;  ex_mtr_d = id_memtoReg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      ex_rs_q <= '0;  ex_rt_q <= '0;  ex_wr_q <= '0;
      ex_use_rs_q <= 1'b0;  ex_use_rt_q <= 1'b0;
      ex_rw_q <= 1'b0;  ex_mtr_q <= 1'b0;
      mem_wr_q <= '0;  mem_rw_q <= 1'b0;  mem_mtr_q <= 1'b0;
      wb_wr_q <= '0;  wb_rw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ex_rs_q <= ex_rs_d;  ex_rt_q <= ex_rt_d;  ex_wr_q <= ex_wr_d;
      ex_use_rs_q <= ex_use_rs_d;  ex_use_rt_q <= ex_use_rt_d;
      ex_rw_q <= ex_rw_d;  ex_mtr_q <= ex_mtr_d;
      mem_wr_q <= mem_wr_d;  mem_rw_q <= mem_rw_d;  mem_mtr_q <= mem_mtr_d;
      wb_wr_q <= wb_wr_d;  wb_rw_q <= wb_rw_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!freeze && lu && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stallCount = stall_cnt_q;
`else
  assign stallCount = 32'h0;
`endif

endmodule
